traffic_light_fsm: RTL and testbench

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm.sv | 106 ++++++++++
 tb/tb_traffic_light_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// ============================================================================
// Module   : traffic_light_fsm
// Brief    : Moore controller for a main/side street crossing with walk phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_fsm #(
    parameter logic [1:0] INT_BASE = 2'd0,
    parameter logic [1:0] INT_EXT  = 2'd1,
    parameter logic [1:0] INT_YEL  = 2'd2
) (
    input  logic       clock,
    input  logic       Reset_Sync,
    input  logic       Expired,
    input  logic       Sensor_Sync,
    input  logic       WR,
    output logic [1:0] Interval,
    output logic       Start_Timer,
    output logic       WR_Reset,
    output logic [6:0] LEDs
);

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG   = 3'd4,
        SGX  = 3'd5,
        SY   = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   start_q, start_d;
    logic   wr_reset_q, wr_reset_d;
    logic   walk_pending_q, walk_pending_d;
    logic   accepted;
    logic   enter_walk;

    // Start_Timer comes up high in reset so the Timer is loaded with the MG1
    // interval the moment reset is released.
    always_ff @(posedge clock or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q        <= MG1;
            start_q        <= 1'b1;
            wr_reset_q     <= 1'b0;
            walk_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            wr_reset_q     <= wr_reset_d;
            walk_pending_q <= walk_pending_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        // An expiry seen while the Timer is being restarted belongs to the old interval.
        accepted = Expired & ~start_q;
        if (accepted) begin
            case (state_q)
                MG1:     state_d = Sensor_Sync ? MY : MG2;
                MG2:     state_d = MY;
                MY:      state_d = walk_pending_q ? WALK : SG;
                WALK:    state_d = SG;
                SG:      state_d = Sensor_Sync ? SGX : SY;
                SGX:     state_d = SY;
                SY:      state_d = MG1;
                default: state_d = MG1;
            endcase
        end

        enter_walk = (state_d == WALK) && (state_q != WALK);
        start_d    = (state_d != state_q);
        wr_reset_d = enter_walk;

        walk_pending_d = walk_pending_q;
        if (enter_walk) begin
            walk_pending_d = 1'b0;
        end else if (WR && (state_q != WALK)) begin
            walk_pending_d = 1'b1;
        end
    end

    always_comb begin
        Interval = INT_BASE;
        LEDs     = 7'b0011000;
        case (state_q)
            MG1:     begin Interval = INT_BASE; LEDs = 7'b0011000; end
            MG2:     begin Interval = INT_BASE; LEDs = 7'b0011000; end
            MY:      begin Interval = INT_YEL;  LEDs = 7'b0101000; end
            WALK:    begin Interval = INT_EXT;  LEDs = 7'b1001001; end
            SG:      begin Interval = INT_BASE; LEDs = 7'b1000010; end
            SGX:     begin Interval = INT_EXT;  LEDs = 7'b1000010; end
            SY:      begin Interval = INT_YEL;  LEDs = 7'b1000100; end
            default: begin Interval = INT_BASE; LEDs = 7'b0011000; end
        endcase
    end

    assign Start_Timer = start_q;
    assign WR_Reset    = wr_reset_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
// ============================================================================
// Module   : tb_traffic_light_fsm
// Brief    : Directed scoreboard bench for traffic_light_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_fsm;

    logic       clock = 1'b0;
    logic       Reset_Sync;
    logic       Expired;
    logic       Sensor_Sync;
    logic       WR;
    logic [1:0] Interval;
    logic       Start_Timer;
    logic       WR_Reset;
    logic [6:0] LEDs;

    int checks = 0;
    int errors = 0;

    // {Start_Timer, WR_Reset, Interval, LEDs}
    logic [10:0] exp_q[$];

    localparam logic [6:0] L_MG   = 7'b0011000;
    localparam logic [6:0] L_MY   = 7'b0101000;
    localparam logic [6:0] L_WALK = 7'b1001001;
    localparam logic [6:0] L_SG   = 7'b1000010;
    localparam logic [6:0] L_SY   = 7'b1000100;
    localparam logic [1:0] I_B    = 2'd0;
    localparam logic [1:0] I_E    = 2'd1;
    localparam logic [1:0] I_Y    = 2'd2;
    localparam logic [10:0] RESET_VAL = {1'b1, 1'b0, 2'd0, 7'b0011000};

    traffic_light_fsm dut (
        .clock       (clock),
        .Reset_Sync  (Reset_Sync),
        .Expired     (Expired),
        .Sensor_Sync (Sensor_Sync),
        .WR          (WR),
        .Interval    (Interval),
        .Start_Timer (Start_Timer),
        .WR_Reset    (WR_Reset),
        .LEDs        (LEDs)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] obs();
        return {Start_Timer, WR_Reset, Interval, LEDs};
    endfunction

    task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // One accepted expiry; expected post-transition outputs go through the queue.
    task automatic step(input string tag, input logic [1:0] ei, input logic [6:0] el,
                        input logic ewr, input logic sens, input logic hold);
        logic [10:0] e;
        int n;
        exp_q.push_back({1'b1, ewr, ei, el});
        Sensor_Sync = sens;
        Expired     = 1'b1;
        @(negedge clock);
        if (!hold) Expired = 1'b0;
        n = 0;
        while (Start_Timer !== 1'b1 && n < 4) begin
            @(negedge clock);
            n++;
        end
        e = exp_q.pop_front();
        chk({tag, "_start"}, obs(), e);
        if (hold) begin
            @(negedge clock);
            Expired = 1'b0;
        end
        @(negedge clock);
        chk({tag, "_hold"}, obs(), {2'b00, e[8:0]});
    endtask

    task automatic pulse_wr();
        WR = 1'b1;
        @(negedge clock);
        WR = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        Reset_Sync  = 1'b1;
        Expired     = 1'b0;
        Sensor_Sync = 1'b0;
        WR          = 1'b0;
        #1;
        chk("reset_async", obs(), RESET_VAL);
        @(negedge clock);
        @(negedge clock);
        chk("reset_held", obs(), RESET_VAL);
        Reset_Sync = 1'b0;
        @(negedge clock);
        chk("release", obs(), {2'b00, I_B, L_MG});

        // Plain cycle, no side traffic, no walk request
        step("p_mg2", I_B, L_MG, 1'b0, 1'b0, 1'b0);
        step("p_my",  I_Y, L_MY, 1'b0, 1'b0, 1'b0);
        step("p_sg",  I_B, L_SG, 1'b0, 1'b0, 1'b0);
        step("p_sy",  I_Y, L_SY, 1'b0, 1'b0, 1'b0);
        step("p_mg1", I_B, L_MG, 1'b0, 1'b0, 1'b0);

        // Side traffic present at MG1 and SG expiries
        step("s_my",  I_Y, L_MY, 1'b0, 1'b1, 1'b0);
        step("s_sg",  I_B, L_SG, 1'b0, 1'b1, 1'b0);
        step("s_sgx", I_E, L_SG, 1'b0, 1'b1, 1'b0);
        step("s_sy",  I_Y, L_SY, 1'b0, 1'b0, 1'b0);
        step("s_mg1", I_B, L_MG, 1'b0, 1'b0, 1'b0);

        // Walk request during MG2; WR during WALK must not re-arm
        step("w_mg2", I_B, L_MG, 1'b0, 1'b0, 1'b0);
        pulse_wr();
        step("w_my",   I_Y, L_MY,   1'b0, 1'b0, 1'b0);
        step("w_walk", I_E, L_WALK, 1'b1, 1'b0, 1'b0);
        pulse_wr();
        step("w_sg",  I_B, L_SG, 1'b0, 1'b0, 1'b0);
        step("w_sy",  I_Y, L_SY, 1'b0, 1'b0, 1'b0);
        step("w_mg1", I_B, L_MG, 1'b0, 1'b0, 1'b0);
        step("w_my2", I_Y, L_MY, 1'b0, 1'b1, 1'b0);
        step("w_sg2", I_B, L_SG, 1'b0, 1'b0, 1'b0);

        // Expired held across the restart cycle: exactly one transition
        step("h_sy",  I_Y, L_SY, 1'b0, 1'b0, 1'b1);
        step("h_mg1", I_B, L_MG, 1'b0, 1'b0, 1'b0);

        // Async reset in SGX with a walk request pending
        step("r_my",  I_Y, L_MY, 1'b0, 1'b1, 1'b0);
        step("r_sg",  I_B, L_SG, 1'b0, 1'b1, 1'b0);
        step("r_sgx", I_E, L_SG, 1'b0, 1'b1, 1'b0);
        pulse_wr();
        #1 Reset_Sync = 1'b1;
        #1 chk("r_async", obs(), RESET_VAL);
        @(negedge clock);
        Reset_Sync = 1'b0;
        @(negedge clock);
        chk("r_release", obs(), {2'b00, I_B, L_MG});
        step("r_my2", I_Y, L_MY, 1'b0, 1'b1, 1'b0);
        step("r_sg2", I_B, L_SG, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
